otbn_pq_bfly_pipe: RTL and testbench
====================================

# otbn_pq_bfly_pipe

Parametrised, multi-lane, 4-stage pipelined PQ modular-arithmetic unit for the OTBN PQ extension. Each lane performs modular add, subtract, Montgomery multiply, or one Cooley-Tukey (CT) or Gentleman-Sande (GS) NTT butterfly on PQLEN-bit coefficients. It succeeds the single-cycle PQ ALU datapath with configurable lane count, a pipelined datapath and a valid/ready handshake. It sits between the WDR read ports and the PQ writeback mux.

## Interface
Parameters:
- PQLEN, 32: coefficient width W; Montgomery radix R = 2^W.
- NLanes, 8: number of parallel lanes; WLEN = NLanes*PQLEN.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- valid_i  in  1  operation present.
- ready_o  out  1  operation accepted when valid_i && ready_o.
- op_i  in  3  0 Add, 1 Sub, 2 Mul, 3 CT, 4 GS; 5-7 reserved.
- a_i, b_i  in  NLanes*PQLEN each  operands; lane k occupies bits [k*W +: W].
- twiddle_i  in  NLanes*PQLEN  per-lane twiddle, in Montgomery form.
- prime_i  in  PQLEN  modulus q.
- prime_dash_i  in  PQLEN  q' = -q^-1 mod R.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts.
- d0_o, d1_o  out  NLanes*PQLEN each  results.
- err_o  out  1  range error; see Configuration.

## Operation
- mont(x,y) = x*y*R^-1 mod q:
  - t = x*y (2W bits).
  - m = (t mod R)*q' mod R.
  - u = (t + m*q) >> W, computed at 2W+1 bits.
  - result = u-q if u >= q, else u.
- Preconditions:
  - q is odd and q < 2^(W-1).
  - All operands < q.
  - Under these preconditions every output is < q.
- Modular add: (W+1)-bit sum; subtract q if sum >= q.
- Modular subtract: difference; add q if it is negative.
- Per lane:
  - Add: d0 = a+b mod q; d1 = 0.
  - Sub: d0 = a-b mod q; d1 = 0.
  - Mul: d0 = mont(a,b); d1 = 0.
  - CT: d0 = a + mont(b,w) mod q; d1 = a - mont(b,w) mod q.
  - GS: d0 = a+b mod q; d1 = mont(a-b mod q, w).
  - Reserved op: d0 = d1 = 0; err_o = 1 when the macro is defined.
- Pipeline stages (op, q, q' and pass-through operands travel with each stage):
  - S1: pre-add/sub. For GS, form the sum and x = a-b mod q. Select multiplier operands: Mul (a,b); CT (b,w); GS (x,w).
  - S2: full product t.
  - S3: m = t[W-1:0]*q' mod R.
  - S4: u and its conditional subtract, then post-add/sub (CT). Results are registered into the output regs.
- Global stall:
  - advance = !valid_o || ready_i.
  - ready_o = advance. This is a combinational path from ready_i.
  - When advance = 0, all stage registers, including valid bits, hold.
  - Each stage valid bit shifts on advance; S1 loads valid_i && ready_o.
  - Bubbles propagate; data in invalid stages is don't-care, but outputs are 0 when valid_o = 0.

## Timing
- Latency: 4 cycles from acceptance to valid_o, with no stall. Uniform for all ops.
- Throughput: 1 op/cycle per all NLanes.
- Reset values: valid_o = 0, d0_o = 0, d1_o = 0, err_o = 0, all stage valids 0.
- ready_o is 1 during the first cycle after reset.
- Reset mid-operation discards all in-flight ops. No output is produced for them.
- Stall with valid_o && !ready_i:
  - d0_o, d1_o and err_o hold stable.
  - An upstream op with valid_i high is not accepted.
- Simultaneous output handshake and new input in the same cycle: both occur, and the pipeline shifts.
- Wrap cases:
  - a+b >= q wraps.
  - a-b < 0 wraps.
  - u in [q, 2q) reduces once.

## Configuration
- OTBN_PQ_RANGE_CHECK_EN defined:
  - S1 flags any lane with a >= q, b >= q, or twiddle >= q (twiddle checked for CT/GS only), and flags reserved ops.
  - The flag pipelines alongside the data; err_o is asserted with the matching valid_o.
  - Results are still computed and carry no correctness guarantee.
- Macro undefined: no check logic is present and err_o is tied to 0.

## Test plan
W=32, NLanes=8, q=8380417, q'=4236238847, Rmod=2^32 mod q=4193792.
- Add with a=q-1, b=2 in all lanes -> after 4 cycles d0=1, d1=0. Sub with a=0, b=1 -> d0=8380416.
- Mul with a=5, b=4193792 -> d0=5. Random a,b < q checked against the reference model x*y*R^-1 mod q.
- CT with a=10, b=3, w=4193792 -> d0=13, d1=7. GS with a=3, b=10, w=4193792 -> d0=13, d1=8380410.
- Back-to-back 20 ops with ready_i low on cycles 6-9:
  - Outputs hold stable while stalled.
  - ready_o is low while valid_o && !ready_i.
  - All 20 results arrive in order with no loss or duplication.
- Reset asserted with 3 ops in flight -> valid_o=0 and outputs 0 the next cycle; no stale result appears afterwards.
- With OTBN_PQ_RANGE_CHECK_EN, lane 3 a=q -> err_o=1 with that result; err_o=0 for legal ops. Without the macro, err_o stays 0.

Source files
------------

// File: rtl/otbn_pq_bfly_pipe.sv
// Multi-lane, 4-stage pipelined PQ modular-arithmetic unit: modular add/sub, Montgomery
// multiply and CT/GS NTT butterflies on PQLEN-bit coefficients, with a valid/ready handshake
// and a global stall.
// Optional range checking is compiled in with `define OTBN_PQ_RANGE_CHECK_EN; without it
// err_o is tied low.
module otbn_pq_bfly_pipe #(
    parameter int unsigned PQLEN  = 32,
    parameter int unsigned NLanes = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [2:0]              op_i,
    input  logic [NLanes*PQLEN-1:0] a_i,
    input  logic [NLanes*PQLEN-1:0] b_i,
    input  logic [NLanes*PQLEN-1:0] twiddle_i,
    input  logic [PQLEN-1:0]        prime_i,
    input  logic [PQLEN-1:0]        prime_dash_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [NLanes*PQLEN-1:0] d0_o,
    output logic [NLanes*PQLEN-1:0] d1_o,
    output logic                    err_o
);

    localparam int unsigned W  = PQLEN;
    localparam int unsigned W1 = PQLEN + 1;

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpMul = 3'd2;
    localparam logic [2:0] OpCt  = 3'd3;
    localparam logic [2:0] OpGs  = 3'd4;

    typedef logic [PQLEN-1:0]   coef_t;
    typedef logic [2*PQLEN-1:0] prod_t;
    typedef logic [NLanes-1:0][PQLEN-1:0]   lanes_t;
    typedef logic [NLanes-1:0][2*PQLEN-1:0] prods_t;

    // (x + y) mod q for x, y < q
    function automatic coef_t mod_add(coef_t x, coef_t y, coef_t q);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, q}) s = s - {1'b0, q};
        return s[W-1:0];
    endfunction

    // (x - y) mod q for x, y < q; the top bit of the difference is the borrow
    function automatic coef_t mod_sub(coef_t x, coef_t y, coef_t q);
        logic [W:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[W]) d = d + {1'b0, q};
        return d[W-1:0];
    endfunction

    // Final Montgomery step: u = (t + m*q) / R, then one conditional subtract (u < 2q)
    function automatic coef_t mont_reduce(prod_t t, coef_t m, coef_t q);
        logic [2*W:0] mq;
        logic [2*W:0] s;
        logic [W:0]   u;
        mq = {{W1{1'b0}}, m} * {{W1{1'b0}}, q};
        s  = {1'b0, t} + mq;
        u  = W1'(s >> W);
        if (u >= {1'b0, q}) u = u - {1'b0, q};
        return u[W-1:0];
    endfunction

    lanes_t a_lane, b_lane, w_lane;
    assign a_lane = a_i;
    assign b_lane = b_i;
    assign w_lane = twiddle_i;

    logic advance;
    assign advance = !valid_o || ready_i;
    assign ready_o = advance;

    // Stage registers. p carries the pass-through coefficient (sum, difference or a).
    logic   s1_valid_q, s2_valid_q, s3_valid_q, out_valid_q;
    logic [2:0] s1_op_q, s2_op_q, s3_op_q;
    coef_t  s1_prime_q, s2_prime_q, s3_prime_q;
    coef_t  s1_pdash_q, s2_pdash_q;
    lanes_t s1_p_d, s1_p_q, s2_p_q, s3_p_q;
    lanes_t s1_x_d, s1_x_q, s1_y_d, s1_y_q;
    prods_t s2_t_d, s2_t_q, s3_t_q;
    lanes_t s3_m_d, s3_m_q;
    lanes_t d0_d, d0_q, d1_d, d1_q;

    // S1: pre-add/sub and multiplier operand selection
    always_comb begin
        s1_p_d = '0;
        s1_x_d = '0;
        s1_y_d = '0;
        for (int k = 0; k < NLanes; k++) begin
            case (op_i)
                OpAdd: s1_p_d[k] = mod_add(a_lane[k], b_lane[k], prime_i);
                OpSub: s1_p_d[k] = mod_sub(a_lane[k], b_lane[k], prime_i);
                OpMul: begin
                    s1_x_d[k] = a_lane[k];
                    s1_y_d[k] = b_lane[k];
                end
                OpCt: begin
                    s1_p_d[k] = a_lane[k];
                    s1_x_d[k] = b_lane[k];
                    s1_y_d[k] = w_lane[k];
                end
                OpGs: begin
                    s1_p_d[k] = mod_add(a_lane[k], b_lane[k], prime_i);
                    s1_x_d[k] = mod_sub(a_lane[k], b_lane[k], prime_i);
                    s1_y_d[k] = w_lane[k];
                end
                default: ;
            endcase
        end
    end

    // S2: full product; S3: Montgomery quotient m = t * q' mod R (W-bit product truncates)
    always_comb begin
        s2_t_d = '0;
        s3_m_d = '0;
        for (int k = 0; k < NLanes; k++) begin
            s2_t_d[k] = {{W{1'b0}}, s1_x_q[k]} * {{W{1'b0}}, s1_y_q[k]};
            s3_m_d[k] = s2_t_q[k][W-1:0] * s2_pdash_q;
        end
    end

    // S4: reduction and CT post-add/sub, op-dependent result routing
    always_comb begin
        coef_t red;
        d0_d = '0;
        d1_d = '0;
        for (int k = 0; k < NLanes; k++) begin
            red = mont_reduce(s3_t_q[k], s3_m_q[k], s3_prime_q);
            case (s3_op_q)
                OpAdd, OpSub: d0_d[k] = s3_p_q[k];
                OpMul: d0_d[k] = red;
                OpCt: begin
                    d0_d[k] = mod_add(s3_p_q[k], red, s3_prime_q);
                    d1_d[k] = mod_sub(s3_p_q[k], red, s3_prime_q);
                end
                OpGs: begin
                    d0_d[k] = s3_p_q[k];
                    d1_d[k] = red;
                end
                default: ;
            endcase
        end
    end

    // Datapath stage registers: no reset needed, qualified by the valid bits
    always_ff @(posedge clk_i) begin
        if (advance) begin
            s1_op_q    <= op_i;
            s1_prime_q <= prime_i;
            s1_pdash_q <= prime_dash_i;
            s1_p_q     <= s1_p_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s2_op_q    <= s1_op_q;
            s2_prime_q <= s1_prime_q;
            s2_pdash_q <= s1_pdash_q;
            s2_p_q     <= s1_p_q;
            s2_t_q     <= s2_t_d;
            s3_op_q    <= s2_op_q;
            s3_prime_q <= s2_prime_q;
            s3_p_q     <= s2_p_q;
            s3_t_q     <= s2_t_q;
            s3_m_q     <= s3_m_d;
        end
    end

    // Valid chain and output registers; outputs are forced to zero on bubbles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            d0_q        <= '0;
            d1_q        <= '0;
        end else if (advance) begin
            s1_valid_q  <= valid_i && ready_o;
            s2_valid_q  <= s1_valid_q;
            s3_valid_q  <= s2_valid_q;
            out_valid_q <= s3_valid_q;
            d0_q        <= s3_valid_q ? d0_d : '0;
            d1_q        <= s3_valid_q ? d1_d : '0;
        end
    end

    assign valid_o = out_valid_q;
    assign d0_o    = d0_q;
    assign d1_o    = d1_q;

`ifdef OTBN_PQ_RANGE_CHECK_EN
    logic s1_err_d, s1_err_q, s2_err_q, s3_err_q, err_q;

    // Flag out-of-range operands (twiddle only matters for butterflies) and reserved ops
    always_comb begin
        s1_err_d = (op_i > OpGs);
        for (int k = 0; k < NLanes; k++) begin
            s1_err_d |= (a_lane[k] >= prime_i) || (b_lane[k] >= prime_i) ||
                        (((op_i == OpCt) || (op_i == OpGs)) && (w_lane[k] >= prime_i));
        end
    end

    // Error flag travels with its operation and is only visible with valid_o
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_err_q <= 1'b0;
            s2_err_q <= 1'b0;
            s3_err_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (advance) begin
            s1_err_q <= s1_err_d;
            s2_err_q <= s1_err_q;
            s3_err_q <= s2_err_q;
            err_q    <= s3_valid_q && s3_err_q;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_otbn_pq_bfly_pipe.sv
// Self-checking bench for otbn_pq_bfly_pipe (W=32, 8 lanes, Dilithium prime).
module tb_otbn_pq_bfly_pipe;

    localparam int unsigned W  = 32;
    localparam int unsigned NL = 8;
    localparam int unsigned WL = W * NL;
    localparam longint unsigned Q    = 64'd8380417;
    localparam longint unsigned QD   = 64'd4236238847;
    localparam longint unsigned RMOD = 64'd4193792;
`ifdef OTBN_PQ_RANGE_CHECK_EN
    localparam bit RangeChk = 1'b1;
`else
    localparam bit RangeChk = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [2:0]    op_i;
    logic [WL-1:0] a_i, b_i, twiddle_i;
    logic [W-1:0]  prime_i, prime_dash_i;
    logic          valid_o;
    logic          ready_i;
    logic [WL-1:0] d0_o, d1_o;
    logic          err_o;

    always #5 clk = ~clk;

    otbn_pq_bfly_pipe #(.PQLEN(W), .NLanes(NL)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .twiddle_i   (twiddle_i),
        .prime_i     (prime_i),
        .prime_dash_i(prime_dash_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .d0_o        (d0_o),
        .d1_o        (d1_o),
        .err_o       (err_o)
    );

    typedef struct {
        logic [WL-1:0] d0;
        logic [WL-1:0] d1;
        logic          err;
        bit            chk;
    } exp_t;

    exp_t            sb[$];
    int              n_err = 0;
    int              n_chk = 0;
    longint unsigned rinv;
    bit              acc;

    task automatic check(input string tag, input logic [WL-1:0] obs, input logic [WL-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // x*y*R^-1 mod q via a precomputed inverse of R
    function automatic longint unsigned mont_ref(longint unsigned x, longint unsigned y);
        return (((x * y) % Q) * rinv) % Q;
    endfunction

    function automatic exp_t model(logic [2:0] op, logic [WL-1:0] a, logic [WL-1:0] b,
                                   logic [WL-1:0] w);
        exp_t e;
        longint unsigned la, lb, lw, r0, r1, x;
        bit bad;
        e.d0 = '0;
        e.d1 = '0;
        bad  = 1'b0;
        for (int k = 0; k < NL; k++) begin
            la = {32'd0, a[k*W +: W]};
            lb = {32'd0, b[k*W +: W]};
            lw = {32'd0, w[k*W +: W]};
            if (la >= Q || lb >= Q || ((op == 3'd3 || op == 3'd4) && lw >= Q)) bad = 1'b1;
            r0 = 0;
            r1 = 0;
            case (op)
                3'd0: r0 = (la + lb) % Q;
                3'd1: r0 = (la + Q - lb) % Q;
                3'd2: r0 = mont_ref(la, lb);
                3'd3: begin
                    x  = mont_ref(lb, lw);
                    r0 = (la + x) % Q;
                    r1 = (la + Q - x) % Q;
                end
                3'd4: begin
                    r0 = (la + lb) % Q;
                    x  = (la + Q - lb) % Q;
                    r1 = mont_ref(x, lw);
                end
                default: ;
            endcase
            e.d0[k*W +: W] = r0[W-1:0];
            e.d1[k*W +: W] = r1[W-1:0];
        end
        e.err = RangeChk && (bad || op > 3'd4);
        e.chk = !bad;
        return e;
    endfunction

    function automatic logic [WL-1:0] bcast(longint unsigned v);
        logic [W-1:0] s;
        s = v[W-1:0];
        return {NL{s}};
    endfunction

    function automatic logic [WL-1:0] rand_vec();
        logic [WL-1:0] r;
        for (int k = 0; k < NL; k++) r[k*W +: W] = $urandom_range(32'(Q - 1), 0);
        return r;
    endfunction

    // One cycle: drive at negedge, score the output handshake, push accepted ops
    task automatic step(input bit v, input logic [2:0] op, input logic [WL-1:0] a,
                        input logic [WL-1:0] b, input logic [WL-1:0] w, input bit rdy,
                        output bit accepted);
        exp_t e;
        valid_i   = v;
        op_i      = op;
        a_i       = a;
        b_i       = b;
        twiddle_i = w;
        ready_i   = rdy;
        #1;
        if (valid_o && !ready_i) begin
            check("stall_ready_low", {255'd0, ready_o}, '0);
            if (sb.size() > 0 && sb[0].chk) check("stall_d0_hold", d0_o, sb[0].d0);
        end
        if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
                check("stale_output", {255'd0, valid_o}, '0);
            end else begin
                e = sb.pop_front();
                if (e.chk) begin
                    check("d0", d0_o, e.d0);
                    check("d1", d1_o, e.d1);
                end
                check("err", {255'd0, err_o}, {255'd0, e.err});
            end
        end
        accepted = v && ready_o;
        if (accepted) sb.push_back(model(op, a, b, w));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit dummy;
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, '0, '0, '0, 1'b1, dummy);
    endtask

    // Single op with full-latency check and spec literal check of lane 0
    task automatic run_one(input string tag, input logic [2:0] op, input logic [WL-1:0] a,
                           input logic [WL-1:0] b, input logic [WL-1:0] w,
                           input logic [W-1:0] lit0, input logic [W-1:0] lit1);
        bit a_ok;
        step(1'b1, op, a, b, w, 1'b1, a_ok);
        check({tag, "_accept"}, {255'd0, a_ok}, {255'd0, 1'b1});
        for (int i = 0; i < 2; i++) begin
            check({tag, "_early"}, {255'd0, valid_o}, '0);
            idle(1);
        end
        check({tag, "_early"}, {255'd0, valid_o}, '0);
        idle(1);
        check({tag, "_lat4"}, {255'd0, valid_o}, {255'd0, 1'b1});
        check({tag, "_lit_d0"}, {224'd0, d0_o[W-1:0]}, {224'd0, lit0});
        check({tag, "_lit_d1"}, {224'd0, d1_o[W-1:0]}, {224'd0, lit1});
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WL-1:0] ra, rb, rw, va;
        logic [2:0]    rop;
        int            i, cyc;

        rinv = 1;
        for (int k = 0; k < 32; k++) rinv = rinv[0] ? (rinv + Q) / 2 : rinv / 2;

        rst_i        = 1'b1;
        valid_i      = 1'b0;
        ready_i      = 1'b0;
        op_i         = '0;
        a_i          = '0;
        b_i          = '0;
        twiddle_i    = '0;
        prime_i      = Q[W-1:0];
        prime_dash_i = QD[W-1:0];
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", {255'd0, valid_o}, '0);
        check("rst_d0", d0_o, '0);
        check("rst_d1", d1_o, '0);
        check("rst_err", {255'd0, err_o}, '0);
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_ready", {255'd0, ready_o}, {255'd0, 1'b1});

        run_one("add", 3'd0, bcast(Q - 1), bcast(2), '0, 32'd1, 32'd0);
        run_one("sub", 3'd1, bcast(0), bcast(1), '0, 32'd8380416, 32'd0);
        run_one("mul", 3'd2, bcast(5), bcast(RMOD), '0, 32'd5, 32'd0);
        run_one("ct", 3'd3, bcast(10), bcast(3), bcast(RMOD), 32'd13, 32'd7);
        run_one("gs", 3'd4, bcast(3), bcast(10), bcast(RMOD), 32'd13, 32'd8380410);
        run_one("rsvd", 3'd5, bcast(7), bcast(9), bcast(11), 32'd0, 32'd0);

        // Lane 3 out of range: only the error flag is meaningful
        va = bcast(4);
        va[3*W +: W] = Q[W-1:0];
        step(1'b1, 3'd0, va, bcast(1), '0, 1'b1, acc);
        idle(5);
        step(1'b1, 3'd0, bcast(4), bcast(1), '0, 1'b1, acc);
        idle(5);

        // Random Montgomery multiplies, back to back
        for (int k = 0; k < 12; k++) step(1'b1, 3'd2, rand_vec(), rand_vec(), '0, 1'b1, acc);
        idle(6);

        // 20 mixed ops with downstream stall on cycles 6-9
        i   = 0;
        cyc = 0;
        rop = 3'd0;
        ra  = rand_vec();
        rb  = rand_vec();
        rw  = rand_vec();
        while (i < 20 && cyc < 200) begin
            step(1'b1, rop, ra, rb, rw, !(cyc >= 6 && cyc <= 9), acc);
            if (acc) begin
                i++;
                rop = 3'(i % 5);
                ra  = rand_vec();
                rb  = rand_vec();
                rw  = rand_vec();
            end
            cyc++;
        end
        check("stall_accept_count", WL'(i), WL'(20));
        idle(8);
        check("stall_drain", WL'(sb.size()), '0);

        // Reset with three ops in flight
        for (int k = 0; k < 3; k++) step(1'b1, 3'd3, rand_vec(), rand_vec(), rand_vec(), 1'b1, acc);
        rst_i = 1'b1;
        step(1'b0, 3'd0, '0, '0, '0, 1'b1, acc);
        rst_i = 1'b0;
        sb.delete();
        check("midrst_valid", {255'd0, valid_o}, '0);
        check("midrst_d0", d0_o, '0);
        check("midrst_d1", d1_o, '0);
        idle(8);
        check("midrst_no_stale", {255'd0, valid_o}, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
